// File: rtl/rob_mc_pkg.sv
// Shared types for the reorder buffer: CDB writeback bus, ROB entry, commit/rename record.
// No logic, types only. ROB_MC_DEBUG_EN adds the per-commit debug record.
// Widths here are the defaults the rob_mc parameters are expected to match.
package rob_mc_pkg;

    localparam int RMC_ROB_ENTRY = 16;
    localparam int RMC_IDX_W     = $clog2(RMC_ROB_ENTRY);
    localparam int RMC_PC_W      = 16;
    localparam int RMC_DATA_W    = 32;
    localparam int RMC_PREG_W    = 6;
    localparam int RMC_FLAGS_W   = 4;

    typedef struct packed {
        logic                   valid;
        logic [RMC_IDX_W-1:0]   rob_dest;
        logic [RMC_DATA_W-1:0]  result;
        logic [RMC_FLAGS_W-1:0] flags;
    } CDB_t;

    typedef struct packed {
        logic [RMC_PC_W-1:0]    pc;
        logic [RMC_PC_W-1:0]    pred_pc;
        logic                   is_spec;
        logic                   is_store;
        logic                   w_v;
        logic [RMC_PREG_W-1:0]  alloc_reg;
        logic [RMC_PREG_W-1:0]  freed_reg;
        logic [RMC_FLAGS_W-1:0] flag_mask;
    } rob_mc_entry_t;

    typedef struct packed {
        logic                   w_v;
        logic [RMC_PREG_W-1:0]  alloc_reg;
        logic [RMC_PREG_W-1:0]  freed_reg;
        logic [RMC_FLAGS_W-1:0] flag_mask;
        logic [RMC_FLAGS_W-1:0] flags;
    } commit_rename_t;

    localparam int CDB_WIDTH           = $bits(CDB_t);
    localparam int ROB_MC_ENTRY_WIDTH  = $bits(rob_mc_entry_t);
    localparam int COMMIT_RENAME_WIDTH = $bits(commit_rename_t);

`ifdef ROB_MC_DEBUG_EN
    typedef struct packed {
        logic [RMC_PC_W-1:0]    pc;
        logic                   is_store;
        logic                   w_v;
        logic [RMC_PREG_W-1:0]  addr;
        logic [RMC_DATA_W-1:0]  result;
    } rob_mc_debug_t;

    localparam int DEBUG_WIDTH = $bits(rob_mc_debug_t);
`endif

endpackage

// File: rtl/rob_mc_commit_sel.sv
// Picks the retiring prefix of the commit window: done entries, one store max, stop after a mispredict.
// Latency: purely combinational.
// Backpressure: an unfinished slot or a second store closes the prefix.
import rob_mc_pkg::*;

module rob_mc_commit_sel #(
    parameter  int COMMIT_W = 2,
    localparam int RW       = $clog2(COMMIT_W + 1),
    localparam int SW       = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
    input  logic [COMMIT_W-1:0] slot_vld_i,
    input  logic [COMMIT_W-1:0] slot_wb_i,
    input  logic [COMMIT_W-1:0] slot_store_i,
    input  logic [COMMIT_W-1:0] slot_mispred_i,
    output logic [COMMIT_W-1:0] commit_vld_o,
    output logic [RW-1:0]       retire_cnt_o,
    output logic                store_o,
    output logic                flush_o,
    output logic [SW-1:0]       flush_slot_o
);

    logic open;

    always_comb begin
        commit_vld_o = '0;
        retire_cnt_o = '0;
        store_o      = 1'b0;
        flush_o      = 1'b0;
        flush_slot_o = '0;
        open         = 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (open && slot_vld_i[k] && slot_wb_i[k] && !(slot_store_i[k] && store_o)) begin
                commit_vld_o[k] = 1'b1;
                retire_cnt_o    = retire_cnt_o + RW'(1);
                if (slot_store_i[k]) store_o = 1'b1;
                // a mispredicted branch is the youngest thing allowed to retire
                if (slot_mispred_i[k]) begin
                    flush_o      = 1'b1;
                    flush_slot_o = SW'(k);
                    open         = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_mc.sv
// Reorder buffer: ISSUE_W in-order alloc, NUM_FU CDB writeback, COMMIT_W in-order retire, flush on mispredict.
// Latency: writeback visible to commit next cycle; flush/redirect combinational with the branch retiring.
// Backpressure: issue_ready_o low when free < ISSUE_W or flushing. Macro ROB_MC_DEBUG_EN adds debug ports.
import rob_mc_pkg::*;

module rob_mc #(
    parameter int ROB_ENTRY = RMC_ROB_ENTRY,
    parameter int ISSUE_W   = 2,
    parameter int COMMIT_W  = 2,
    parameter int NUM_FU    = 4,
    parameter int PC_W      = RMC_PC_W
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  CDB_t           [NUM_FU-1:0]            cdb_i,
    input  logic           [ISSUE_W-1:0]           issue_valid_i,
    input  rob_mc_entry_t  [ISSUE_W-1:0]           issue_entry_i,
    output logic                                   issue_ready_o,
    output logic           [ISSUE_W-1:0][$clog2(ROB_ENTRY)-1:0] issue_idx_o,
    output logic           [COMMIT_W-1:0]          commit_valid_o,
    output commit_rename_t [COMMIT_W-1:0]          commit_entry_o,
    output logic                                   sb_pop_o,
    output logic                                   flush_o,
    output logic           [PC_W-1:0]              redirect_pc_o
`ifdef ROB_MC_DEBUG_EN
    ,
    output logic           [COMMIT_W-1:0]          debug_valid_o,
    output rob_mc_debug_t  [COMMIT_W-1:0]          debug_o
`endif
);

    localparam int IDX_W = $clog2(ROB_ENTRY);
    localparam int CNT_W = IDX_W + 1;
    localparam int AW    = $clog2(ISSUE_W + 1);
    localparam int RW    = $clog2(COMMIT_W + 1);
    localparam int SW    = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

    rob_mc_entry_t          ent_q   [ROB_ENTRY];
    rob_mc_entry_t          ent_d   [ROB_ENTRY];
    logic [PC_W-1:0]        rpc_q   [ROB_ENTRY];
    logic [PC_W-1:0]        rpc_d   [ROB_ENTRY];
    logic [RMC_FLAGS_W-1:0] flags_q [ROB_ENTRY];
    logic [RMC_FLAGS_W-1:0] flags_d [ROB_ENTRY];
`ifdef ROB_MC_DEBUG_EN
    logic [RMC_DATA_W-1:0]  res_q   [ROB_ENTRY];
    logic [RMC_DATA_W-1:0]  res_d   [ROB_ENTRY];
`endif
    logic [ROB_ENTRY-1:0]   valid_q, valid_d, wb_q, wb_d, mp_q, mp_d;
    logic [IDX_W-1:0]       alloc_pt_q, alloc_pt_d, rd_pt_q, rd_pt_d;
    logic [CNT_W-1:0]       free_q, free_d;

    logic [IDX_W-1:0]       win_idx [COMMIT_W];
    logic [COMMIT_W-1:0]    win_vld, win_wb, win_st, win_mp;
    logic [COMMIT_W-1:0]    sel_vld;
    logic [RW-1:0]          ret_cnt;
    logic                   sel_store, sel_flush;
    logic [SW-1:0]          flush_slot;
    logic [AW-1:0]          n_alloc;

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            win_idx[k] = rd_pt_q + IDX_W'(k);
            win_vld[k] = valid_q[win_idx[k]];
            win_wb[k]  = wb_q[win_idx[k]];
            win_st[k]  = ent_q[win_idx[k]].is_store;
            win_mp[k]  = mp_q[win_idx[k]];
        end
    end

    rob_mc_commit_sel #(.COMMIT_W(COMMIT_W)) u_commit_sel (
        .slot_vld_i     (win_vld),
        .slot_wb_i      (win_wb),
        .slot_store_i   (win_st),
        .slot_mispred_i (win_mp),
        .commit_vld_o   (sel_vld),
        .retire_cnt_o   (ret_cnt),
        .store_o        (sel_store),
        .flush_o        (sel_flush),
        .flush_slot_o   (flush_slot)
    );

    // reset dominates: nothing leaves the ROB while reset_i is high
    assign issue_ready_o  = !reset_i && !sel_flush && (free_q >= CNT_W'(ISSUE_W));
    assign commit_valid_o = reset_i ? '0 : sel_vld;
    assign sb_pop_o       = sel_store && !reset_i;
    assign flush_o        = sel_flush && !reset_i;
    assign redirect_pc_o  = flush_o ? rpc_q[win_idx[flush_slot]] : '0;

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) issue_idx_o[k] = alloc_pt_q + IDX_W'(k);
    end

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            commit_entry_o[k] = '0;
            if (commit_valid_o[k]) begin
                commit_entry_o[k].w_v       = ent_q[win_idx[k]].w_v;
                commit_entry_o[k].alloc_reg = ent_q[win_idx[k]].alloc_reg;
                commit_entry_o[k].freed_reg = ent_q[win_idx[k]].freed_reg;
                commit_entry_o[k].flag_mask = ent_q[win_idx[k]].flag_mask;
                commit_entry_o[k].flags     = flags_q[win_idx[k]];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        mp_d    = mp_q;
        ent_d   = ent_q;
        rpc_d   = rpc_q;
        flags_d = flags_q;
`ifdef ROB_MC_DEBUG_EN
        res_d   = res_q;
`endif
        n_alloc = '0;
        for (int k = 0; k < ISSUE_W; k++)
            if (issue_valid_i[k]) n_alloc = n_alloc + AW'(1);
        if (!issue_ready_o) n_alloc = '0;

        // scan ports high to low so the lowest-numbered port lands last and wins
        for (int i = 0; i < ROB_ENTRY; i++) begin
            for (int j = NUM_FU - 1; j >= 0; j--) begin
                if (cdb_i[j].valid && cdb_i[j].rob_dest == IDX_W'(i) && valid_q[i] && !wb_q[i]) begin
                    wb_d[i]    = 1'b1;
                    flags_d[i] = cdb_i[j].flags;
                    if (ent_q[i].is_spec) begin
                        rpc_d[i] = cdb_i[j].result[PC_W-1:0];
                        mp_d[i]  = cdb_i[j].result != RMC_DATA_W'(ent_q[i].pred_pc);
                    end
`ifdef ROB_MC_DEBUG_EN
                    if (ent_q[i].w_v) res_d[i] = cdb_i[j].result;
`endif
                end
            end
        end

        for (int k = 0; k < COMMIT_W; k++) begin
            if (sel_vld[k]) begin
                valid_d[win_idx[k]] = 1'b0;
                wb_d[win_idx[k]]    = 1'b0;
            end
        end

        for (int k = 0; k < ISSUE_W; k++) begin
            if (issue_ready_o && issue_valid_i[k]) begin
                valid_d[alloc_pt_q + IDX_W'(k)] = 1'b1;
                wb_d[alloc_pt_q + IDX_W'(k)]    = 1'b0;
                mp_d[alloc_pt_q + IDX_W'(k)]    = 1'b0;
                ent_d[alloc_pt_q + IDX_W'(k)]   = issue_entry_i[k];
            end
        end

        alloc_pt_d = alloc_pt_q + IDX_W'(n_alloc);
        rd_pt_d    = rd_pt_q + IDX_W'(ret_cnt);
        free_d     = free_q - CNT_W'(n_alloc) + CNT_W'(ret_cnt);

        if (sel_flush) begin
            valid_d    = '0;
            wb_d       = '0;
            mp_d       = '0;
            alloc_pt_d = '0;
            rd_pt_d    = '0;
            free_d     = CNT_W'(ROB_ENTRY);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q    <= '0;
            wb_q       <= '0;
            mp_q       <= '0;
            alloc_pt_q <= '0;
            rd_pt_q    <= '0;
            free_q     <= CNT_W'(ROB_ENTRY);
            for (int i = 0; i < ROB_ENTRY; i++) begin
                ent_q[i]   <= '0;
                rpc_q[i]   <= '0;
                flags_q[i] <= '0;
`ifdef ROB_MC_DEBUG_EN
                res_q[i]   <= '0;
`endif
            end
        end else begin
            valid_q    <= valid_d;
            wb_q       <= wb_d;
            mp_q       <= mp_d;
            alloc_pt_q <= alloc_pt_d;
            rd_pt_q    <= rd_pt_d;
            free_q     <= free_d;
            ent_q      <= ent_d;
            rpc_q      <= rpc_d;
            flags_q    <= flags_d;
`ifdef ROB_MC_DEBUG_EN
            res_q      <= res_d;
`endif
        end
    end

`ifdef ROB_MC_DEBUG_EN
    assign debug_valid_o = commit_valid_o;

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            debug_o[k] = '0;
            if (commit_valid_o[k]) begin
                debug_o[k].pc       = ent_q[win_idx[k]].pc;
                debug_o[k].is_store = ent_q[win_idx[k]].is_store;
                debug_o[k].w_v      = ent_q[win_idx[k]].w_v;
                debug_o[k].addr     = ent_q[win_idx[k]].alloc_reg;
                debug_o[k].result   = res_q[win_idx[k]];
            end
        end
    end
`else
    // the issue pc is only kept for the debug view
    logic unused_pc;
    always_comb begin
        unused_pc = 1'b0;
        for (int i = 0; i < ROB_ENTRY; i++) unused_pc = unused_pc ^ (^ent_q[i].pc);
    end
`endif

    a_issue_contig: assert property (@(posedge clk_i) disable iff (reset_i)
        ((issue_valid_i & (issue_valid_i + ISSUE_W'(1))) == '0));

endmodule

// File: tb/tb_rob_mc.sv
// Directed scenarios plus random alloc/writeback/reset traffic against a queue-based ROB model.
import rob_mc_pkg::*;

module tb_rob_mc;

    localparam int NE = 16;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int NF = 4;

    logic                         clk_i = 1'b0;
    logic                         reset_i;
    CDB_t           [NF-1:0]      cdb_i;
    logic           [IW-1:0]      issue_valid_i;
    rob_mc_entry_t  [IW-1:0]      issue_entry_i;
    logic                         issue_ready_o;
    logic           [IW-1:0][3:0] issue_idx_o;
    logic           [CW-1:0]      commit_valid_o;
    commit_rename_t [CW-1:0]      commit_entry_o;
    logic                         sb_pop_o;
    logic                         flush_o;
    logic           [15:0]        redirect_pc_o;
`ifdef ROB_MC_DEBUG_EN
    logic           [CW-1:0]      debug_valid_o;
    rob_mc_debug_t  [CW-1:0]      debug_o;
`endif

    rob_mc #(.ROB_ENTRY(NE), .ISSUE_W(IW), .COMMIT_W(CW), .NUM_FU(NF), .PC_W(16)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .cdb_i          (cdb_i),
        .issue_valid_i  (issue_valid_i),
        .issue_entry_i  (issue_entry_i),
        .issue_ready_o  (issue_ready_o),
        .issue_idx_o    (issue_idx_o),
        .commit_valid_o (commit_valid_o),
        .commit_entry_o (commit_entry_o),
        .sb_pop_o       (sb_pop_o),
        .flush_o        (flush_o),
        .redirect_pc_o  (redirect_pc_o)
`ifdef ROB_MC_DEBUG_EN
        ,
        .debug_valid_o  (debug_valid_o),
        .debug_o        (debug_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: program-ordered list of in-flight instructions
    typedef struct {
        int            tag;
        rob_mc_entry_t e;
        bit            done;
        logic [3:0]    flags;
        logic [31:0]   res;
    } m_t;

    m_t            q[$];
    int            next_tag = 0;

    int            drv_n;
    bit            drv_rst;
    rob_mc_entry_t drv_e [IW];
    CDB_t          drv_c [NF];

    function automatic rob_mc_entry_t rent(input bit spec, input bit st, input logic [15:0] pred);
        rob_mc_entry_t e;
        e.pc        = 16'($urandom);
        e.pred_pc   = pred;
        e.is_spec   = spec;
        e.is_store  = st;
        e.w_v       = 1'($urandom);
        e.alloc_reg = 6'($urandom);
        e.freed_reg = 6'($urandom);
        e.flag_mask = 4'($urandom);
        return e;
    endfunction

    task automatic clr();
        drv_n   = 0;
        drv_rst = 0;
        for (int j = 0; j < NF; j++) drv_c[j] = '0;
    endtask

    task automatic setc(input int j, input int tag, input logic [31:0] res);
        drv_c[j].valid    = 1'b1;
        drv_c[j].rob_dest = 4'(tag);
        drv_c[j].result   = res;
        drv_c[j].flags    = 4'($urandom);
    endtask

    // drive one cycle, compare outputs against the model, then advance the model past the edge
    task automatic step();
        logic [CW-1:0]  ecv;
        int             n;
        bit             st, fl, sb, rdy;
        logic [15:0]    rpc;
        commit_rename_t ce;
        m_t             m;
        reset_i       = drv_rst;
        issue_valid_i = (drv_n >= 2) ? 2'b11 : (drv_n == 1) ? 2'b01 : 2'b00;
        for (int k = 0; k < IW; k++) issue_entry_i[k] = drv_e[k];
        for (int j = 0; j < NF; j++) cdb_i[j] = drv_c[j];
        #1;
        ecv = '0; n = 0; st = 0; fl = 0; sb = 0; rpc = '0;
        if (!drv_rst) begin
            for (int k = 0; k < CW && k < q.size(); k++) begin
                if (!q[k].done || (q[k].e.is_store && st)) break;
                ecv[k] = 1'b1;
                n++;
                if (q[k].e.is_store) begin st = 1; sb = 1; end
                if (q[k].e.is_spec && q[k].res != {16'h0, q[k].e.pred_pc}) begin
                    fl  = 1;
                    rpc = q[k].res[15:0];
                    break;
                end
            end
        end
        rdy = !drv_rst && ((NE - q.size()) >= IW) && !fl;
        check("commit_valid", commit_valid_o, ecv);
        check("sb_pop", sb_pop_o, sb);
        check("flush", flush_o, fl);
        check("redirect_pc", redirect_pc_o, rpc);
        check("issue_ready", issue_ready_o, rdy);
        if (!drv_rst) begin
            check("issue_idx0", issue_idx_o[0], next_tag);
            check("issue_idx1", issue_idx_o[1], (next_tag + 1) % NE);
        end
        for (int k = 0; k < n; k++) begin
            ce.w_v       = q[k].e.w_v;
            ce.alloc_reg = q[k].e.alloc_reg;
            ce.freed_reg = q[k].e.freed_reg;
            ce.flag_mask = q[k].e.flag_mask;
            ce.flags     = q[k].flags;
            check("commit_entry", commit_entry_o[k], ce);
        end
        @(posedge clk_i);
        #1;
        if (drv_rst || fl) begin
            q.delete();
            next_tag = 0;
        end else begin
            for (int j = 0; j < NF; j++) begin
                if (drv_c[j].valid) begin
                    foreach (q[i]) begin
                        if (q[i].tag == int'(drv_c[j].rob_dest) && !q[i].done) begin
                            q[i].done  = 1;
                            q[i].flags = drv_c[j].flags;
                            q[i].res   = drv_c[j].result;
                        end
                    end
                end
            end
            repeat (n) void'(q.pop_front());
            if (rdy) begin
                for (int k = 0; k < drv_n; k++) begin
                    m.tag   = next_tag;
                    m.e     = drv_e[k];
                    m.done  = 0;
                    m.flags = '0;
                    m.res   = '0;
                    q.push_back(m);
                    next_tag = (next_tag + 1) % NE;
                end
            end
        end
    endtask

    task automatic gen();
        int          idx;
        logic [31:0] r;
        clr();
        drv_rst = ($urandom_range(0, 149) == 0);
        drv_n   = $urandom_range(0, 2);
        for (int k = 0; k < IW; k++)
            drv_e[k] = rent($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 16'($urandom));
        for (int j = 0; j < NF; j++) begin
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, q.size() - 1);
                if (!q[idx].done) begin
                    if (q[idx].e.is_spec)
                        r = ($urandom_range(0, 2) == 0) ? {16'h0, 16'($urandom)} : {16'h0, q[idx].e.pred_pc};
                    else
                        r = $urandom;
                    setc(j, q[idx].tag, r);
                end
            end
        end
    endtask

    initial begin
        clr();
        for (int k = 0; k < IW; k++) drv_e[k] = '0;
        drv_rst = 1; step(); step(); drv_rst = 0;

        // fill the ROB two per cycle, then one dropped request while full
        for (int c = 0; c < 8; c++) begin
            drv_n = 2; drv_e[0] = rent(0, 0, 0); drv_e[1] = rent(0, 0, 0); step();
        end
        check("full_ready", issue_ready_o, 0);
        step();
        drv_n = 0;

        // hole at the head blocks commit until tag 0 arrives
        setc(0, 1, $urandom); setc(1, 2, $urandom); step(); clr(); step();
        check("hole_no_commit", commit_valid_o, 2'b00);
        setc(0, 0, $urandom); step(); clr();
        check("commit_pair", commit_valid_o, 2'b11);
        step();
        check("commit_tail", commit_valid_o, 2'b01);
        step();

        // two stores at the head, then a mispredicted branch at tag 3
        drv_rst = 1; step(); drv_rst = 0;
        drv_n = 2; drv_e[0] = rent(0, 1, 0); drv_e[1] = rent(0, 1, 0); step();
        drv_e[0] = rent(0, 0, 0); drv_e[1] = rent(1, 0, 16'h0020); step();
        drv_n = 0;
        setc(0, 0, $urandom); setc(1, 1, $urandom); setc(2, 2, $urandom); setc(3, 3, 32'h40);
        step(); clr();
        check("store_prefix", commit_valid_o, 2'b01);
        check("store_pop", sb_pop_o, 1);
        step();
        check("store_then_plain", commit_valid_o, 2'b11);
        step();
        check("mp_flush", flush_o, 1);
        check("mp_redirect", redirect_pc_o, 16'h0040);
        check("mp_commit", commit_valid_o, 2'b01);
        step();
        check("post_flush_ready", issue_ready_o, 1);
        check("post_flush_idx", issue_idx_o[0], 0);

        // correctly predicted branch retires without a flush
        drv_n = 1; drv_e[0] = rent(1, 0, 16'h0020); step();
        drv_n = 0; setc(0, 0, 32'h20); step(); clr();
        check("bp_ok_commit", commit_valid_o, 2'b01);
        check("bp_ok_noflush", flush_o, 0);
        step();

        // reset asserted in the flush cycle wins
        drv_n = 1; drv_e[0] = rent(1, 0, 16'h0020); step();
        drv_n = 0; setc(0, 1, 32'h40); step(); clr();
        check("rf_flush_pending", flush_o, 1);
        drv_rst = 1; step();
        check("rf_flush_cleared", flush_o, 0);
        check("rf_commit_cleared", commit_valid_o, 2'b00);
        check("rf_ready_in_reset", issue_ready_o, 0);
        clr(); step();

        repeat (3000) begin
            gen();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
